// File: rtl/stream_demux_router.sv
// 1-to-N_OUT valid/ready stream demultiplexer. The destination port is locked
// from the first beat of a packet to in_last, and each port has a one-entry holding register.
module stream_demux_router #(
    parameter int DATA_W = 8,
    parameter int N_OUT  = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_last,
    input  logic [SEL_W-1:0]        in_sel,
    output logic [N_OUT-1:0]        out_valid,
    input  logic [N_OUT-1:0]        out_ready,
    output logic [N_OUT*DATA_W-1:0] out_data,
    output logic [N_OUT-1:0]        out_last,
    output logic                    err_sel
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // N_OUT is widened by one bit so that N_OUT == 2**SEL_W still compares correctly.
    localparam logic [SEL_W:0] N_OUT_W = N_OUT[SEL_W:0];

    logic [1:0]              state_q, state_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    err_q, err_d;
    logic [N_OUT-1:0]        valid_q, valid_d;
    logic [N_OUT-1:0]        last_q, last_d;
    logic [N_OUT*DATA_W-1:0] data_q, data_d;

    logic [SEL_W-1:0]        tgt;
    logic [N_OUT-1:0]        tgt_oh;
    logic [N_OUT-1:0]        wr_oh;
    logic                    sel_ok;
    logic                    discard;
    logic                    port_free;
    logic                    accept;

    // Routing decision. An illegal state value routes like IDLE.
    always_comb begin : route
        // NOTE: every signal written here gets a value before any branch, so no latch is inferred.
        sel_ok  = ({1'b0, in_sel} < N_OUT_W);
        tgt     = (state_q == ST_FWD) ? sel_q : in_sel;
        discard = (state_q == ST_DROP) || ((state_q != ST_FWD) && !sel_ok);
        for (int i = 0; i < N_OUT; i++) begin
            tgt_oh[i] = (tgt == SEL_W'(i));
        end
        // A held beat that drains on this edge frees the slot immediately.
        port_free = |(tgt_oh & (~valid_q | out_ready));
        in_ready  = discard | port_free;
        accept    = in_valid & in_ready;
        wr_oh     = (accept && !discard) ? tgt_oh : '0;
    end

    // Per-port holding registers: the drain clears valid and a refill on the same edge wins.
    always_comb begin : port_next
        valid_d = valid_q & ~out_ready;
        last_d  = last_q;
        data_d  = data_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (wr_oh[i]) begin
                valid_d[i]                 = 1'b1;
                last_d[i]                  = in_last;
                data_d[i*DATA_W +: DATA_W] = in_data;
            end
        end
    end

    always_comb begin : fsm_next
        state_d = state_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        case (state_q)
            ST_FWD: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            ST_DROP: begin
                if (accept && in_last) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (sel_ok) sel_d = in_sel;
                    else        err_d = 1'b1;
                    if (!in_last) state_d = sel_ok ? ST_FWD : ST_DROP;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            err_q   <= 1'b0;
            valid_q <= '0;
            last_q  <= '0;
            // NOTE: the payload registers are reset as well because out_data must read zero after reset.
            data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so that every register samples pre-edge values.
            state_q <= state_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_last  = last_q;
    assign out_data  = data_q;
    assign err_sel   = err_q;

endmodule

// File: tb/tb_stream_demux_router.sv
// Testbench for stream_demux_router. It checks a 4-port instance against a
// packet-level reference model and a 3-port instance for out-of-range selects.
module tb_stream_demux_router;

    localparam int DW = 8;
    localparam int NA = 4;
    localparam int NB = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Instance A: four ports
    logic          a_in_valid, a_in_ready, a_in_last, a_err_sel;
    logic [DW-1:0] a_in_data;
    logic [1:0]    a_in_sel;
    logic [NA-1:0] a_out_valid, a_out_ready, a_out_last;
    logic [NA*DW-1:0] a_out_data;

    // Instance B: three ports, so in_sel=3 is out of range
    logic          b_in_valid, b_in_ready, b_in_last, b_err_sel;
    logic [DW-1:0] b_in_data;
    logic [1:0]    b_in_sel;
    logic [NB-1:0] b_out_valid, b_out_ready, b_out_last;
    logic [NB*DW-1:0] b_out_data;

    stream_demux_router #(.DATA_W(DW), .N_OUT(NA), .SEL_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_last(a_in_last), .in_sel(a_in_sel),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_last(a_out_last), .err_sel(a_err_sel)
    );

    stream_demux_router #(.DATA_W(DW), .N_OUT(NB), .SEL_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .in_sel(b_in_sel),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_last(b_out_last), .err_sel(b_err_sel)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model for instance A: the beat held at each port, plus the packet lock.
    // m_lock: -1 = no packet open, -2 = dropping a packet, >=0 = port locked to.
    logic          m_valid [NA];
    logic [DW-1:0] m_data  [NA];
    logic          m_last  [NA];
    logic          m_err;
    int            m_lock;

    task automatic model_reset();
        for (int i = 0; i < NA; i++) begin
            m_valid[i] = 1'b0;
            m_data[i]  = '0;
            m_last[i]  = 1'b0;
        end
        m_err  = 1'b0;
        m_lock = -1;
    endtask

    // One clock cycle on instance A: drive, check against the model, advance the model.
    task automatic drive_cycle(input logic v, input logic [DW-1:0] d, input logic l,
                               input logic [1:0] s, input logic [NA-1:0] r,
                               output logic acc);
        int t;
        logic drop, exp_rdy, fire, opening;
        logic [NA-1:0] ev, el;
        logic [NA*DW-1:0] ed;
        @(negedge clk);
        a_in_valid  = v;
        a_in_data   = d;
        a_in_last   = l;
        a_in_sel    = s;
        a_out_ready = r;
        #1;
        for (int i = 0; i < NA; i++) begin
            ev[i]          = m_valid[i];
            el[i]          = m_last[i];
            ed[i*DW +: DW] = m_data[i];
        end
        opening = (m_lock == -1);
        if (m_lock >= 0) begin
            t = m_lock; drop = 1'b0;
        end else if (m_lock == -2) begin
            t = 0; drop = 1'b1;
        end else begin
            t = int'(s); drop = (t >= NA);
        end
        exp_rdy = drop ? 1'b1 : (!m_valid[t] || r[t]);

        n_cmp++;
        if (a_in_ready !== exp_rdy) begin
            n_err++; $display("FAIL in_ready: got %b expected %b", a_in_ready, exp_rdy);
        end
        n_cmp++;
        if (a_out_valid !== ev) begin
            n_err++; $display("FAIL out_valid: got %b expected %b", a_out_valid, ev);
        end
        n_cmp++;
        if (a_out_data !== ed) begin
            n_err++; $display("FAIL out_data: got %h expected %h", a_out_data, ed);
        end
        n_cmp++;
        if (a_out_last !== el) begin
            n_err++; $display("FAIL out_last: got %b expected %b", a_out_last, el);
        end
        n_cmp++;
        if (a_err_sel !== m_err) begin
            n_err++; $display("FAIL err_sel: got %b expected %b", a_err_sel, m_err);
        end

        acc  = v && a_in_ready;
        fire = v && exp_rdy;
        m_err = fire && opening && drop;
        for (int i = 0; i < NA; i++) begin
            if (m_valid[i] && r[i]) m_valid[i] = 1'b0;
        end
        if (fire && !drop) begin
            m_valid[t] = 1'b1;
            m_data[t]  = d;
            m_last[t]  = l;
        end
        if (fire) begin
            if (l)            m_lock = -1;
            else if (opening) m_lock = drop ? -2 : t;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 8'hFF;
        a_in_last   = 1'b0;
        a_in_sel    = 2'd1;
        a_out_ready = '1;
        b_in_valid  = 1'b1;
        b_in_sel    = 2'd3;
        b_in_data   = 8'hEE;
        b_in_last   = 1'b0;
        b_out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (a_out_valid !== '0) begin n_err++; $display("FAIL reset out_valid: got %b expected 0", a_out_valid); end
        n_cmp++;
        if (a_out_data !== '0) begin n_err++; $display("FAIL reset out_data: got %h expected 0", a_out_data); end
        n_cmp++;
        if (a_out_last !== '0) begin n_err++; $display("FAIL reset out_last: got %b expected 0", a_out_last); end
        n_cmp++;
        if (a_err_sel !== 1'b0) begin n_err++; $display("FAIL reset err_sel: got %b expected 0", a_err_sel); end
        n_cmp++;
        if (b_err_sel !== 1'b0 || b_out_valid !== '0) begin
            n_err++; $display("FAIL reset b outputs: got err=%b valid=%b expected 0", b_err_sel, b_out_valid);
        end
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        rst_n      = 1'b1;
        model_reset();
    endtask

    task automatic test_single_beat();
        logic acc;
        drive_cycle(1'b1, 8'hA5, 1'b1, 2'd2, 4'hF, acc);
        n_cmp++;
        if (a_out_valid !== 4'b0100) begin n_err++; $display("FAIL single out_valid: got %b expected 0100", a_out_valid); end
        n_cmp++;
        if (a_out_data[2*DW +: DW] !== 8'hA5) begin
            n_err++; $display("FAIL single port2 data: got %h expected a5", a_out_data[2*DW +: DW]);
        end
        n_cmp++;
        if (a_out_last[2] !== 1'b1) begin n_err++; $display("FAIL single port2 last: got %b expected 1", a_out_last[2]); end
        // Back in IDLE: the next beat follows its own in_sel.
        drive_cycle(1'b1, 8'h3C, 1'b1, 2'd0, 4'hF, acc);
        n_cmp++;
        if (a_out_valid !== 4'b0001) begin n_err++; $display("FAIL single reselect: got %b expected 0001", a_out_valid); end
        drive_cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, acc);
    endtask

    task automatic test_packet_lock();
        logic acc;
        logic [DW-1:0] beats [3];
        logic [1:0]    sels  [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        sels[0]  = 2'd1;  sels[1]  = 2'd3;  sels[2]  = 2'd3;
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, beats[k], (k == 2), sels[k], 4'hF, acc);
            n_cmp++;
            if (a_out_valid !== 4'b0010 || a_out_data[DW +: DW] !== beats[k]) begin
                n_err++; $display("FAIL lock beat%0d: got valid=%b data=%h expected valid=0010 data=%h",
                                  k, a_out_valid, a_out_data[DW +: DW], beats[k]);
            end
            n_cmp++;
            if (a_out_data[3*DW +: DW] !== 8'h00) begin
                n_err++; $display("FAIL lock port3 touched: got %h expected 00", a_out_data[3*DW +: DW]);
            end
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, acc);
    endtask

    task automatic test_backpressure();
        logic acc;
        int   n_acc;
        drive_cycle(1'b1, 8'hB0, 1'b0, 2'd0, 4'hF, acc);
        for (int k = 0; k < 5; k++) begin
            drive_cycle(1'b1, 8'hB1, 1'b0, 2'd3, 4'b1110, acc);
            n_cmp++;
            if (acc !== 1'b0) begin n_err++; $display("FAIL stall accept: got %b expected 0", acc); end
            n_cmp++;
            if (a_out_data[DW-1:0] !== 8'hB0 || a_out_valid[0] !== 1'b1) begin
                n_err++; $display("FAIL stall hold: got data=%h valid=%b expected b0 1",
                                  a_out_data[DW-1:0], a_out_valid[0]);
            end
        end
        n_acc = 0;
        for (int k = 1; k <= 8; k++) begin
            drive_cycle(1'b1, 8'hB0 + DW'(k), (k == 8), 2'd2, 4'hF, acc);
            if (acc) n_acc++;
        end
        n_cmp++;
        if (n_acc != 8) begin n_err++; $display("FAIL full rate: got %0d beats expected 8", n_acc); end
        drive_cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, acc);
    endtask

    task automatic test_bad_select();
        // First beat to port 3 of a 3-port instance: accepted and dropped.
        @(negedge clk);
        b_in_valid = 1'b1; b_in_sel = 2'd3; b_in_data = 8'h55; b_in_last = 1'b0; b_out_ready = '1;
        #1;
        n_cmp++;
        if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL bad sel ready0: got %b expected 1", b_in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (b_err_sel !== 1'b1) begin n_err++; $display("FAIL bad sel err pulse: got %b expected 1", b_err_sel); end
        n_cmp++;
        if (b_out_valid !== '0) begin n_err++; $display("FAIL bad sel valid0: got %b expected 000", b_out_valid); end
        // Second beat: still dropping, in_sel ignored, no new pulse.
        @(negedge clk);
        b_in_sel = 2'd0; b_in_data = 8'h66; b_in_last = 1'b1;
        #1;
        n_cmp++;
        if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL bad sel ready1: got %b expected 1", b_in_ready); end
        @(posedge clk); #1;
        n_cmp++;
        if (b_err_sel !== 1'b0) begin n_err++; $display("FAIL bad sel err width: got %b expected 0", b_err_sel); end
        n_cmp++;
        if (b_out_valid !== '0) begin n_err++; $display("FAIL bad sel valid1: got %b expected 000", b_out_valid); end
        // A legal packet afterwards routes normally.
        @(negedge clk);
        b_in_sel = 2'd2; b_in_data = 8'h77; b_in_last = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (b_out_valid !== 3'b100 || b_out_data[2*DW +: DW] !== 8'h77 || b_err_sel !== 1'b0) begin
            n_err++; $display("FAIL bad sel recover: got valid=%b data=%h err=%b expected 100 77 0",
                              b_out_valid, b_out_data[2*DW +: DW], b_err_sel);
        end
        @(negedge clk);
        b_in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        logic acc;
        drive_cycle(1'b1, 8'hC0, 1'b0, 2'd2, 4'hF, acc);
        drive_cycle(1'b1, 8'hC1, 1'b0, 2'd2, 4'hF, acc);
        @(negedge clk);
        a_in_valid = 1'b0;
        rst_n      = 1'b0;
        #1;
        n_cmp++;
        if (a_out_valid !== '0 || a_out_data !== '0) begin
            n_err++; $display("FAIL mid reset clear: got valid=%b data=%h expected 0", a_out_valid, a_out_data);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        drive_cycle(1'b1, 8'hD0, 1'b1, 2'd0, 4'hF, acc);
        n_cmp++;
        if (a_out_valid !== 4'b0001 || a_out_data[DW-1:0] !== 8'hD0) begin
            n_err++; $display("FAIL mid reset reroute: got valid=%b data=%h expected 0001 d0",
                              a_out_valid, a_out_data[DW-1:0]);
        end
        drive_cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, acc);
    endtask

    task automatic test_random();
        logic acc;
        logic [NA-1:0] r;
        for (int k = 0; k < 600; k++) begin
            for (int i = 0; i < NA; i++) r[i] = ($urandom_range(9, 0) < 7);
            drive_cycle(($urandom_range(3, 0) != 0), DW'($urandom), ($urandom_range(3, 0) == 0),
                        2'($urandom_range(3, 0)), r, acc);
        end
        for (int k = 0; k < 4; k++) drive_cycle(1'b0, 8'h00, 1'b0, 2'd0, 4'hF, acc);
    endtask

    initial begin
        rst_n       = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_last = 1'b0; a_in_sel = '0; a_out_ready = '1;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_in_sel = '0; b_out_ready = '1;
        model_reset();
        test_reset();
        test_single_beat();
        test_packet_lock();
        test_backpressure();
        test_bad_select();
        test_reset_mid_packet();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
